// File: rtl/l2tlb_pkg.sv
// Shared L2TLB definitions: SPTBR tracker defaults, tracker FSM states and the
// l2tlbtol1tlb snoop/sack channel payloads.
package l2tlb_pkg;

    localparam int L2TLB_SPTBR_W     = 44;
    localparam int L2TLB_N_SPTBR     = 4;
    localparam int L2TLB_SPTBR_IDX_W = $clog2(L2TLB_N_SPTBR);

    typedef enum logic [1:0] {
        SPTBR_IDLE      = 2'd0,
        SPTBR_SNOOP     = 2'd1,
        SPTBR_WAIT_SACK = 2'd2
    } sptbr_state_e;

    typedef struct packed {
        logic [L2TLB_SPTBR_IDX_W-1:0] idx;
    } l2tlbtol1tlb_snoop_t;

    typedef struct packed {
        logic [L2TLB_SPTBR_IDX_W-1:0] idx;
    } l2tlbtol1tlb_sack_t;

endpackage

// File: rtl/l2tlb_sptbr_cam.sv
// Combinational SPTBR lookup over the tracking table: per-entry match, index of
// the (unique) matching entry, lowest free slot and table-full flag.
module l2tlb_sptbr_cam
    import l2tlb_pkg::*;
#(
    parameter  int N     = L2TLB_N_SPTBR,
    parameter  int W     = L2TLB_SPTBR_W,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]        i_vld,
    input  logic [N-1:0][W-1:0] i_tag,
    input  logic [W-1:0]        i_key,
    output logic [N-1:0]        o_match,
    output logic [IDX_W-1:0]    o_hit_idx,
    output logic [IDX_W-1:0]    o_free_idx,
    output logic                o_full
);

    always_comb begin
        o_match   = '0;
        o_hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            o_match[i] = i_vld[i] && (i_tag[i] == i_key);
            // Entries are unique, so OR-ing indices yields the single match.
            if (i_vld[i] && (i_tag[i] == i_key)) begin
                o_hit_idx = o_hit_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        o_free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!i_vld[i]) begin
                o_free_idx = IDX_W'(i);
            end
        end
    end

    assign o_full = &i_vld;

endmodule

// File: rtl/l2tlb_sptbr_tracker.sv
// Maps SPTBRs to small TLB tag indices; on a full table evicts a round-robin
// victim after snooping the L1TLB for that index and waiting for its ack.
module l2tlb_sptbr_tracker
    import l2tlb_pkg::*;
#(
    parameter  int SPTBR_W = L2TLB_SPTBR_W,
    parameter  int N_SPTBR = L2TLB_N_SPTBR,
    localparam int IDX_W   = $clog2(N_SPTBR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_retry,
    input  logic [SPTBR_W-1:0] req_sptbr,
    output logic               rsp_valid,
    input  logic               rsp_retry,
    output logic [IDX_W-1:0]   rsp_idx,
    output logic               rsp_hit,
    output logic               snoop_valid,
    input  logic               snoop_retry,
    output logic [IDX_W-1:0]   snoop_idx,
    input  logic               sack_valid,
    output logic               sack_retry,
    input  logic [IDX_W-1:0]   sack_idx,
    output logic               sack_err
);

    sptbr_state_e                     r_state;
    sptbr_state_e                     w_state_nxt;
    logic [N_SPTBR-1:0]               r_vld;
    logic [N_SPTBR-1:0][SPTBR_W-1:0]  r_sptbr;
    logic [IDX_W-1:0]                 r_rr;
    logic [IDX_W-1:0]                 r_victim;
    logic [SPTBR_W-1:0]               r_req_sptbr;
    logic                             r_rsp_valid;
    logic [IDX_W-1:0]                 r_rsp_idx;
    logic                             r_rsp_hit;

    logic [N_SPTBR-1:0]               w_match;
    logic [IDX_W-1:0]                 w_hit_idx;
    logic [IDX_W-1:0]                 w_free_idx;
    logic                             w_full;
    logic                             w_hit;
    logic                             w_accept;
    logic                             w_req_retry;
    logic                             w_snoop_valid;
    logic                             w_sack_ok;
    logic [IDX_W-1:0]                 w_rr_nxt;

    l2tlb_sptbr_cam #(
        .N (N_SPTBR),
        .W (SPTBR_W)
    ) u_cam (
        .i_vld      (r_vld),
        .i_tag      (r_sptbr),
        .i_key      (req_sptbr),
        .o_match    (w_match),
        .o_hit_idx  (w_hit_idx),
        .o_free_idx (w_free_idx),
        .o_full     (w_full)
    );

    assign w_hit    = |w_match;
    assign w_rr_nxt = (r_rr == IDX_W'(N_SPTBR - 1)) ? '0 : r_rr + IDX_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_req_retry   = 1'b1;
        w_accept      = 1'b0;
        w_snoop_valid = 1'b0;
        w_sack_ok     = 1'b0;
        case (r_state)
            SPTBR_IDLE: begin
                w_req_retry = r_rsp_valid && rsp_retry;
                w_accept    = req_valid && !w_req_retry;
                if (w_accept && !w_hit && w_full) begin
                    w_state_nxt = SPTBR_SNOOP;
                end
            end
            SPTBR_SNOOP: begin
                w_snoop_valid = 1'b1;
                if (!snoop_retry) begin
                    w_state_nxt = SPTBR_WAIT_SACK;
                end
            end
            SPTBR_WAIT_SACK: begin
                if (sack_valid && (sack_idx == r_victim)) begin
                    w_sack_ok   = 1'b1;
                    w_state_nxt = SPTBR_IDLE;
                end
            end
            default: begin
                w_state_nxt = SPTBR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SPTBR_IDLE;
            r_vld       <= '0;
            r_rr        <= '0;
            r_victim    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_rsp_valid && !rsp_retry) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_hit) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_idx   <= w_hit_idx;
                    r_rsp_hit   <= 1'b1;
                end else if (!w_full) begin
                    r_vld[w_free_idx] <= 1'b1;
                    r_rsp_valid       <= 1'b1;
                    r_rsp_idx         <= w_free_idx;
                    r_rsp_hit         <= 1'b0;
                end else begin
                    // Victim stops matching at once so stale tags cannot hit mid-eviction.
                    r_vld[r_rr] <= 1'b0;
                    r_victim    <= r_rr;
                end
            end
            if (w_sack_ok) begin
                r_vld[r_victim] <= 1'b1;
                r_rr            <= w_rr_nxt;
                r_rsp_valid     <= 1'b1;
                r_rsp_idx       <= r_victim;
                r_rsp_hit       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !w_hit) begin
            if (!w_full) begin
                r_sptbr[w_free_idx] <= req_sptbr;
            end else begin
                r_req_sptbr <= req_sptbr;
            end
        end
        if (w_sack_ok) begin
            r_sptbr[r_victim] <= r_req_sptbr;
        end
    end

    assign req_retry   = w_req_retry;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_idx     = r_rsp_idx;
    assign rsp_hit     = r_rsp_hit;
    assign snoop_valid = w_snoop_valid;
    assign snoop_idx   = r_victim;
    assign sack_retry  = 1'b0;
    assign sack_err    = sack_valid && !w_sack_ok;

endmodule

// File: tb/tb_l2tlb_sptbr_tracker.sv
// Scoreboard bench for l2tlb_sptbr_tracker: expected responses are queued when
// requests are driven and popped when the response channel transfers.
module tb_l2tlb_sptbr_tracker;

    localparam int SW = 44;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_retry;
    logic [SW-1:0] req_sptbr;
    logic          rsp_valid;
    logic          rsp_retry;
    logic [IW-1:0] rsp_idx;
    logic          rsp_hit;
    logic          snoop_valid;
    logic          snoop_retry;
    logic [IW-1:0] snoop_idx;
    logic          sack_valid;
    logic          sack_retry;
    logic [IW-1:0] sack_idx;
    logic          sack_err;

    typedef struct {
        int idx;
        bit hit;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    l2tlb_sptbr_tracker #(
        .SPTBR_W (SW),
        .N_SPTBR (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_retry   (req_retry),
        .req_sptbr   (req_sptbr),
        .rsp_valid   (rsp_valid),
        .rsp_retry   (rsp_retry),
        .rsp_idx     (rsp_idx),
        .rsp_hit     (rsp_hit),
        .snoop_valid (snoop_valid),
        .snoop_retry (snoop_retry),
        .snoop_idx   (snoop_idx),
        .sack_valid  (sack_valid),
        .sack_retry  (sack_retry),
        .sack_idx    (sack_idx),
        .sack_err    (sack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: a transfer happens at the next edge when valid && !retry.
    always @(negedge clk) begin
        if (reset && rsp_valid && !rsp_retry) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_idx", 64'(rsp_idx), 64'(e.idx));
                check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
            end
        end
    end

    task automatic do_req(input logic [SW-1:0] s, input int idx, input bit hit);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        sb.push_back('{idx, hit});
        req_valid = 1'b1;
        req_sptbr = s;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (!req_retry) acc = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) check("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic evict(input logic [SW-1:0] s, input int victim, input int r, input bit bad);
        int t_acc;
        @(posedge clk); #1;
        sb.push_back('{victim, 1'b0});
        req_valid = 1'b1;
        req_sptbr = s;
        @(negedge clk);
        check("ev_accept", 64'(req_retry), 64'd0);
        t_acc = cyc;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        snoop_retry = (r > 0);
        if (r > 0) begin
            sack_valid = 1'b1;
            sack_idx   = IW'(victim);
        end
        for (int i = 0; i < r; i++) begin
            @(negedge clk);
            check("snp_hold_valid", 64'(snoop_valid), 64'd1);
            check("snp_hold_idx", 64'(snoop_idx), 64'(victim));
            check("snp_hold_reqretry", 64'(req_retry), 64'd1);
            if (i == 0) check("sack_in_snoop_err", 64'(sack_err), 64'd1);
            @(posedge clk); #1;
            sack_valid = 1'b0;
            if (i == r - 1) snoop_retry = 1'b0;
        end
        @(negedge clk);
        check("snp_valid", 64'(snoop_valid), 64'd1);
        check("snp_idx", 64'(snoop_idx), 64'(victim));
        check("snp_reqretry", 64'(req_retry), 64'd1);
        @(posedge clk); #1;
        if (bad) begin
            sack_valid = 1'b1;
            sack_idx   = (victim == 3) ? IW'(0) : IW'(3);
            @(negedge clk);
            check("bad_sack_err", 64'(sack_err), 64'd1);
            check("bad_sack_snoop", 64'(snoop_valid), 64'd0);
            check("bad_sack_reqretry", 64'(req_retry), 64'd1);
            @(posedge clk); #1;
            sack_valid = 1'b0;
            @(negedge clk);
            check("bad_sack_pulse", 64'(sack_err), 64'd0);
            check("bad_sack_norsp", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        sack_valid = 1'b1;
        sack_idx   = IW'(victim);
        @(negedge clk);
        check("good_sack_err", 64'(sack_err), 64'd0);
        check("good_sack_norsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        sack_valid = 1'b0;
        @(negedge clk);
        check("ev_rsp_valid", 64'(rsp_valid), 64'd1);
        check("ev_latency", 64'(cyc - t_acc), 64'(3 + r + (bad ? 2 : 0)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_sptbr   = '0;
        rsp_retry   = 1'b0;
        snoop_retry = 1'b0;
        sack_valid  = 1'b0;
        sack_idx    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_idx", 64'(rsp_idx), 64'd0);
        check("rst_rsp_hit", 64'(rsp_hit), 64'd0);
        check("rst_req_retry", 64'(req_retry), 64'd0);
        check("rst_snoop_valid", 64'(snoop_valid), 64'd0);
        check("rst_snoop_idx", 64'(snoop_idx), 64'd0);
        check("rst_sack_retry", 64'(sack_retry), 64'd0);
        check("rst_sack_err", 64'(sack_err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        do_req(44'h100, 0, 1'b0);
        @(negedge clk);
        check("alloc_latency", 64'(rsp_valid), 64'd1);
        do_req(44'h100, 0, 1'b1);
        do_req(44'h101, 1, 1'b0);
        do_req(44'h102, 2, 1'b0);
        do_req(44'h103, 3, 1'b0);

        evict(44'h200, 0, 0, 1'b0);
        evict(44'h300, 1, 0, 1'b0);
        evict(44'h100, 2, 0, 1'b0);
        do_req(44'h103, 3, 1'b1);
        do_req(44'h200, 0, 1'b1);

        evict(44'h400, 3, 5, 1'b0);
        evict(44'h500, 0, 0, 1'b1);

        // Response backpressure: second request must wait until rsp drains.
        @(posedge clk); #1;
        rsp_retry = 1'b1;
        req_valid = 1'b1;
        req_sptbr = 44'h500;
        sb.push_back('{0, 1'b1});
        @(negedge clk);
        check("bp_first_accept", 64'(req_retry), 64'd0);
        @(posedge clk); #1;
        req_sptbr = 44'h300;
        sb.push_back('{1, 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req_retry", 64'(req_retry), 64'd1);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_idx", 64'(rsp_idx), 64'd0);
            check("bp_rsp_hit", 64'(rsp_hit), 64'd1);
            @(posedge clk); #1;
        end
        rsp_retry = 1'b0;
        @(negedge clk);
        check("bp_release_accept", 64'(req_retry), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while waiting for the sack of an eviction (victim 1).
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_sptbr = 44'h600;
        @(negedge clk);
        check("rmid_accept", 64'(req_retry), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmid_snoop_valid", 64'(snoop_valid), 64'd1);
        check("rmid_snoop_idx", 64'(snoop_idx), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rmid_rst_snoop_valid", 64'(snoop_valid), 64'd0);
        check("rmid_rst_snoop_idx", 64'(snoop_idx), 64'd0);
        check("rmid_rst_req_retry", 64'(req_retry), 64'd0);
        check("rmid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        sack_valid = 1'b1;
        sack_idx   = IW'(1);
        @(negedge clk);
        check("stale_sack_err", 64'(sack_err), 64'd1);
        @(posedge clk); #1;
        sack_valid = 1'b0;
        do_req(44'h600, 0, 1'b0);
        do_req(44'h100, 1, 1'b0);

        repeat (4) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2tlb_sptbr_tracker.md
# l2tlb_sptbr_tracker

Parametrised SPTBR tracking table for the L2TLB, generalising the fixed four-slot SPTBR-to-index map into an N-entry table with eviction. It maps each incoming page-table base (SPTBR) to a small index used to tag TLB entries. When the table is full, it evicts a round-robin victim: it snoops the L1TLB to invalidate every entry carrying that index, waits for the snoop ack, then reuses the slot. It sits inside the l2tlb, between the L1TLB request path and the l2tlbtol1tlb snoop/sack channels.

## Interface
- SPTBR_W, 44, SPTBR (root PPN) width
- N_SPTBR, 4, tracked SPTBRs (≥2, need not be a power of two); localparam IDX_W = $clog2(N_SPTBR)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request
- req_retry  out  1  request stall
- req_sptbr  in  SPTBR_W  SPTBR to translate
- rsp_valid  out  1  response valid
- rsp_retry  in  1  response stall
- rsp_idx  out  IDX_W  assigned index
- rsp_hit  out  1  1 = SPTBR already tracked, 0 = newly allocated
- snoop_valid  out  1  invalidate-index snoop to L1TLB
- snoop_retry  in  1  snoop stall
- snoop_idx  out  IDX_W  index to invalidate
- sack_valid  in  1  snoop ack from L1TLB
- sack_retry  out  1  constant 0
- sack_idx  in  IDX_W  acked index
- sack_err  out  1  one-cycle pulse: unexpected or mismatched sack

## Operation
- Handshake on every channel: transfer when valid && !retry; the sender holds valid and data stable while retry is high.
- State: per entry {vld, sptbr}; rr pointer; one response register; FSM IDLE / SNOOP / WAIT_SACK; latched request sptbr and victim index.
- IDLE: req_retry = rsp_valid && rsp_retry. On accept, look up combinationally:
  - hit (vld && sptbr match): rsp {idx, hit=1}
  - miss with a free slot: allocate the lowest free index and write the entry; rsp {idx, hit=0}
  - miss with the table full: victim = rr; clear victim vld immediately; latch sptbr/victim; go to SNOOP
- SNOOP: req_retry=1; snoop_valid=1, snoop_idx=victim; go to WAIT_SACK on transfer.
- WAIT_SACK: req_retry=1. A sack with sack_idx == victim writes the entry {1, latched sptbr}, advances rr (N_SPTBR-1 wraps to 0), loads rsp {victim, hit=0}, and returns to IDLE.
- Sacks are always consumed. A sack in IDLE/SNOOP, or with a mismatched idx, pulses sack_err and changes no state.
- Duplicate SPTBRs never exist: a lookup matches at most one entry.
- rr advances only on eviction, not on free-slot allocation.

## Timing
- Reset values (asserted asynchronously): all vld=0, rr=0, FSM=IDLE, rsp_valid=0, rsp_idx=0, rsp_hit=0, snoop_valid=0, snoop_idx=0, req_retry=0, sack_retry=0, sack_err=0.
- Hit or free-slot allocation: rsp_valid rises the cycle after acceptance. Back-to-back accepts are possible at one per cycle while rsp drains.
- Eviction: request accepted at cycle T, snoop_valid at T+1, earliest sack at T+2, rsp_valid at T+3.
- Response register full with rsp_retry high: req_retry=1, and no lookup occurs.
- A sack arriving in the same cycle snoop transfers is illegal and is flagged as sack_err.
- Reset mid-eviction: the pending snoop and request are dropped, and the table is empty afterwards. Later stale sacks raise sack_err.

## Structure
- Put SPTBR_W default, N_SPTBR default, and the FSM state enum in the shared l2tlb package, alongside the existing l2tlbtol1tlb snoop/sack typedefs. The snoop_idx/sack_idx fields map into those structs at the l2tlb level.
- Sub-module l2tlb_sptbr_cam (parametrised N, W): match vector, hit index, lowest-free index, and full flag. All sequential logic stays in the top module.

## Test plan
- Reset, then request 0x100 → rsp {idx 0, hit 0} one cycle later. Repeat 0x100 → {idx 0, hit 1}.
- Fill with 0x100–0x103, then request 0x200 → snoop_idx 0. Sack idx 0 → rsp {0, hit 0}. Next eviction (0x300) → snoop_idx 1. A later request for 0x100 misses.
- Hold snoop_retry=1 for 5 cycles during eviction → snoop_valid/idx stable, req_retry=1 throughout, rsp delayed by exactly 5 cycles.
- Sack with idx 3 while waiting on victim 0 → sack_err pulse, still WAIT_SACK. Correct sack idx 0 → completes.
- Hold rsp_retry=1 with a response pending → req_retry=1 and rsp fields stable. Release → next request accepted the same cycle.
- Assert reset in WAIT_SACK → all outputs reset immediately. The following request for the evicting SPTBR allocates idx 0 with hit 0.
